// File: rtl/axi_sram_slave.sv
// AXI slave front-end for one single-port synchronous SRAM macro.
// FIXED/INCR/WRAP bursts, alternating read/write arbitration, SLVERR.
module axi_sram_slave #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int ID_W   = 8,
  parameter int LEN_W  = 4,
  parameter int DEPTH  = 16384
) (
  input  logic                       ACLK,
  input  logic                       ARESET,
  input  logic [ID_W-1:0]            AWID_S,
  input  logic [ADDR_W-1:0]          AWADDR_S,
  input  logic [LEN_W-1:0]           AWLEN_S,
  input  logic [2:0]                 AWSIZE_S,
  input  logic [1:0]                 AWBURST_S,
  input  logic                       AWVALID_S,
  output logic                       AWREADY_S,
  input  logic [DATA_W-1:0]          WDATA_S,
  input  logic [DATA_W/8-1:0]        WSTRB_S,
  input  logic                       WLAST_S,
  input  logic                       WVALID_S,
  output logic                       WREADY_S,
  output logic [ID_W-1:0]            BID_S,
  output logic [1:0]                 BRESP_S,
  output logic                       BVALID_S,
  input  logic                       BREADY_S,
  input  logic [ID_W-1:0]            ARID_S,
  input  logic [ADDR_W-1:0]          ARADDR_S,
  input  logic [LEN_W-1:0]           ARLEN_S,
  input  logic [2:0]                 ARSIZE_S,
  input  logic [1:0]                 ARBURST_S,
  input  logic                       ARVALID_S,
  output logic                       ARREADY_S,
  output logic [ID_W-1:0]            RID_S,
  output logic [DATA_W-1:0]          RDATA_S,
  output logic [1:0]                 RRESP_S,
  output logic                       RLAST_S,
  output logic                       RVALID_S,
  input  logic                       RREADY_S,
  output logic                       CEB,
  output logic                       WEB,
  output logic [DATA_W-1:0]          BWEB,
  output logic [$clog2(DEPTH)-1:0]   A,
  output logic [DATA_W-1:0]          D,
  input  logic [DATA_W-1:0]          Q
);

  localparam int STRB_W = DATA_W / 8;
  localparam int OFF    = $clog2(STRB_W);
  localparam int MA     = $clog2(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    R_BEAT,
    W_BEAT,
    B_RESP
  } state_t;

  state_t              r_state;
  logic                r_last_wr;
  logic [ID_W-1:0]     r_id;
  logic [ADDR_W-1:0]   r_addr;
  logic [LEN_W-1:0]    r_len;
  logic [2:0]          r_size;
  logic [1:0]          r_burst;
  logic [LEN_W-1:0]    r_cnt;
  logic                r_err;
  logic                r_rerr;

  logic                w_idle;
  logic                w_ar_hs;
  logic                w_aw_hs;
  logic                w_r_hs;
  logic                w_w_hs;
  logic                w_rlast;
  logic                w_wlast_cnt;
  logic [ADDR_W-1:0]   w_s_addr;
  logic [LEN_W-1:0]    w_s_cnt;
  logic [LEN_W-1:0]    w_s_len;
  logic [2:0]          w_s_size;
  logic [1:0]          w_s_burst;
  logic [ADDR_W-1:0]   w_beat_addr;
  logic                w_beat_err;
  logic                w_rd_go;
  logic                w_wr_go;
  logic [DATA_W-1:0]   w_bmask;

  function automatic logic [ADDR_W-1:0] f_addr(
    input logic [ADDR_W-1:0] start,
    input logic [LEN_W-1:0]  cnt,
    input logic [LEN_W-1:0]  len,
    input logic [2:0]        size,
    input logic [1:0]        burst
  );
    logic [ADDR_W-1:0] step;
    logic [ADDR_W-1:0] bound;
    logic [ADDR_W-1:0] incr;
    logic [ADDR_W-1:0] mask;
    step  = ADDR_W'(cnt) << size;
    bound = (ADDR_W'(len) + ADDR_W'(1)) << size;
    incr  = start + step;
    mask  = bound - ADDR_W'(1);
    case (burst)
      2'b00:   f_addr = start;
      2'b10:   f_addr = (start & ~mask) | (incr & mask);
      default: f_addr = incr;
    endcase
  endfunction

  function automatic logic f_err(
    input logic [ADDR_W-1:0] addr,
    input logic [LEN_W-1:0]  len,
    input logic [2:0]        size,
    input logic [1:0]        burst
  );
    logic wrap_ok;
    wrap_ok = (len == LEN_W'(1)) || (len == LEN_W'(3)) ||
              (len == LEN_W'(7)) || (len == LEN_W'(15));
    f_err = ((addr >> OFF) >= ADDR_W'(DEPTH)) ||
            (size > 3'(OFF)) ||
            ((burst == 2'b10) && !wrap_ok) ||
            (burst == 2'b11);
  endfunction

  // Conflicting requests go to the side not served last.
  assign w_idle    = !ARESET && (r_state == IDLE);
  assign ARREADY_S = w_idle && !(AWVALID_S && !r_last_wr);
  assign AWREADY_S = w_idle && !(ARVALID_S && r_last_wr);
  assign w_ar_hs   = ARVALID_S && ARREADY_S;
  assign w_aw_hs   = AWVALID_S && AWREADY_S;

  assign RVALID_S  = !ARESET && (r_state == R_BEAT);
  assign WREADY_S  = !ARESET && (r_state == W_BEAT);
  assign BVALID_S  = !ARESET && (r_state == B_RESP);
  assign w_r_hs    = RVALID_S && RREADY_S;
  assign w_w_hs    = WVALID_S && WREADY_S;
  assign w_rlast   = (r_cnt == r_len);
  assign w_wlast_cnt = (r_cnt == r_len);

  assign RID_S   = RVALID_S ? r_id : '0;
  assign RDATA_S = (RVALID_S && !r_rerr) ? Q : '0;
  assign RRESP_S = (RVALID_S && r_rerr) ? 2'b10 : 2'b00;
  assign RLAST_S = RVALID_S && w_rlast;
  assign BID_S   = BVALID_S ? r_id : '0;
  assign BRESP_S = (BVALID_S && r_err) ? 2'b10 : 2'b00;

  // Beat 0 of a read comes straight from AR; later beats from latches.
  always_comb begin
    w_s_addr  = r_addr;
    w_s_cnt   = r_cnt;
    w_s_len   = r_len;
    w_s_size  = r_size;
    w_s_burst = r_burst;
    if (w_ar_hs) begin
      w_s_addr  = ARADDR_S;
      w_s_cnt   = '0;
      w_s_len   = ARLEN_S;
      w_s_size  = ARSIZE_S;
      w_s_burst = ARBURST_S;
    end else if (r_state == R_BEAT) begin
      w_s_cnt   = r_cnt + LEN_W'(1);
    end
  end

  assign w_beat_addr = f_addr(w_s_addr, w_s_cnt, w_s_len,
                              w_s_size, w_s_burst);
  assign w_beat_err  = f_err(w_beat_addr, w_s_len,
                             w_s_size, w_s_burst);

  assign w_rd_go = (w_ar_hs || (w_r_hs && !w_rlast)) && !w_beat_err;
  assign w_wr_go = w_w_hs && !w_beat_err;

  always_comb begin
    w_bmask = '0;
    for (int i = 0; i < STRB_W; i++) begin
      w_bmask[i*8 +: 8] = {8{WSTRB_S[i]}};
    end
  end

  assign CEB  = !(w_rd_go || w_wr_go);
  assign WEB  = !w_wr_go;
  assign BWEB = w_wr_go ? ~w_bmask : '1;
  assign D    = w_wr_go ? WDATA_S : '0;
  assign A    = (w_rd_go || w_wr_go) ?
                w_beat_addr[OFF+MA-1:OFF] : '0;

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_state   <= IDLE;
      r_last_wr <= 1'b1;
      r_id      <= '0;
      r_addr    <= '0;
      r_len     <= '0;
      r_size    <= '0;
      r_burst   <= '0;
      r_cnt     <= '0;
      r_err     <= 1'b0;
      r_rerr    <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_ar_hs) begin
            r_id      <= ARID_S;
            r_addr    <= ARADDR_S;
            r_len     <= ARLEN_S;
            r_size    <= ARSIZE_S;
            r_burst   <= ARBURST_S;
            r_cnt     <= '0;
            r_rerr    <= w_beat_err;
            r_last_wr <= 1'b0;
            r_state   <= R_BEAT;
          end else if (w_aw_hs) begin
            r_id      <= AWID_S;
            r_addr    <= AWADDR_S;
            r_len     <= AWLEN_S;
            r_size    <= AWSIZE_S;
            r_burst   <= AWBURST_S;
            r_cnt     <= '0;
            r_err     <= 1'b0;
            r_last_wr <= 1'b1;
            r_state   <= W_BEAT;
          end
        end
        R_BEAT: begin
          if (w_r_hs) begin
            if (w_rlast) begin
              r_state <= IDLE;
            end else begin
              r_cnt  <= r_cnt + LEN_W'(1);
              r_rerr <= w_beat_err;
            end
          end
        end
        W_BEAT: begin
          if (w_w_hs) begin
            r_cnt <= r_cnt + LEN_W'(1);
            if (w_beat_err || (WLAST_S != w_wlast_cnt)) begin
              r_err <= 1'b1;
            end
            if (w_wlast_cnt) begin
              r_state <= B_RESP;
            end
          end
        end
        B_RESP: begin
          if (BREADY_S) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_sram_slave.sv
// Scoreboard bench for axi_sram_slave with a behavioural SRAM macro.
// Directed bursts; a negedge monitor checks every R and B beat.
module tb_axi_sram_slave;

  logic        ACLK = 1'b0;
  logic        ARESET;
  logic [7:0]  AWID_S;
  logic [31:0] AWADDR_S;
  logic [3:0]  AWLEN_S;
  logic [2:0]  AWSIZE_S;
  logic [1:0]  AWBURST_S;
  logic        AWVALID_S;
  logic        AWREADY_S;
  logic [31:0] WDATA_S;
  logic [3:0]  WSTRB_S;
  logic        WLAST_S;
  logic        WVALID_S;
  logic        WREADY_S;
  logic [7:0]  BID_S;
  logic [1:0]  BRESP_S;
  logic        BVALID_S;
  logic        BREADY_S;
  logic [7:0]  ARID_S;
  logic [31:0] ARADDR_S;
  logic [3:0]  ARLEN_S;
  logic [2:0]  ARSIZE_S;
  logic [1:0]  ARBURST_S;
  logic        ARVALID_S;
  logic        ARREADY_S;
  logic [7:0]  RID_S;
  logic [31:0] RDATA_S;
  logic [1:0]  RRESP_S;
  logic        RLAST_S;
  logic        RVALID_S;
  logic        RREADY_S;
  logic        CEB;
  logic        WEB;
  logic [31:0] BWEB;
  logic [13:0] A;
  logic [31:0] D;
  logic [31:0] Q;

  axi_sram_slave dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .AWID_S(AWID_S), .AWADDR_S(AWADDR_S), .AWLEN_S(AWLEN_S),
    .AWSIZE_S(AWSIZE_S), .AWBURST_S(AWBURST_S),
    .AWVALID_S(AWVALID_S), .AWREADY_S(AWREADY_S),
    .WDATA_S(WDATA_S), .WSTRB_S(WSTRB_S), .WLAST_S(WLAST_S),
    .WVALID_S(WVALID_S), .WREADY_S(WREADY_S),
    .BID_S(BID_S), .BRESP_S(BRESP_S), .BVALID_S(BVALID_S),
    .BREADY_S(BREADY_S),
    .ARID_S(ARID_S), .ARADDR_S(ARADDR_S), .ARLEN_S(ARLEN_S),
    .ARSIZE_S(ARSIZE_S), .ARBURST_S(ARBURST_S),
    .ARVALID_S(ARVALID_S), .ARREADY_S(ARREADY_S),
    .RID_S(RID_S), .RDATA_S(RDATA_S), .RRESP_S(RRESP_S),
    .RLAST_S(RLAST_S), .RVALID_S(RVALID_S), .RREADY_S(RREADY_S),
    .CEB(CEB), .WEB(WEB), .BWEB(BWEB), .A(A), .D(D), .Q(Q)
  );

  always #5 ACLK = ~ACLK;

  logic [31:0] mem [0:16383];
  always @(posedge ACLK) begin
    if (!CEB) begin
      if (!WEB) mem[A] <= (mem[A] & BWEB) | (D & ~BWEB);
      else      Q <= mem[A];
    end
  end

  typedef struct {
    logic [7:0]  id;
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
  } rexp_t;
  typedef struct {
    logic [7:0] id;
    logic [1:0] resp;
  } bexp_t;

  rexp_t rq[$];
  bexp_t bq[$];
  int    n_cmp = 0;
  int    n_fail = 0;
  int    cyc = 0;
  logic  rr_tog = 1'b0;
  logic [31:0] wdat [16];
  logic        wceb [16];

  always @(posedge ACLK) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic rexp_t mk_r(input logic [7:0] id,
      input logic [31:0] d, input logic [1:0] r, input logic l);
    rexp_t e;
    e.id = id; e.data = d; e.resp = r; e.last = l;
    return e;
  endfunction

  function automatic bexp_t mk_b(input logic [7:0] id,
                                 input logic [1:0] r);
    bexp_t e;
    e.id = id; e.resp = r;
    return e;
  endfunction

  initial begin
    RREADY_S = 1'b1;
    forever begin
      @(posedge ACLK);
      #1;
      RREADY_S = rr_tog ? ~RREADY_S : 1'b1;
    end
  end

  initial begin
    forever begin
      @(negedge ACLK);
      if (RVALID_S) begin
        if (rq.size() == 0) chk("r_unexpected", 1, 0);
        else begin
          chk("rid", RID_S, rq[0].id);
          chk("rdata", RDATA_S, rq[0].data);
          chk("rresp", RRESP_S, rq[0].resp);
          chk("rlast", RLAST_S, rq[0].last);
          if (RREADY_S) void'(rq.pop_front());
        end
      end
      if (BVALID_S) begin
        if (bq.size() == 0) chk("b_unexpected", 1, 0);
        else begin
          chk("bid", BID_S, bq[0].id);
          chk("bresp", BRESP_S, bq[0].resp);
          if (BREADY_S) void'(bq.pop_front());
        end
      end
    end
  end

  task automatic ar_send(input logic [7:0] id, input logic [31:0] ad,
      input logic [3:0] len, input logic [2:0] sz,
      input logic [1:0] bu, output int hs);
    ARID_S = id; ARADDR_S = ad; ARLEN_S = len;
    ARSIZE_S = sz; ARBURST_S = bu; ARVALID_S = 1'b1;
    hs = -1;
    for (int k = 0; k < 100; k++) begin
      @(negedge ACLK);
      if (ARREADY_S) begin hs = cyc; break; end
    end
    if (hs < 0) chk("ar_timeout", 0, 1);
    @(posedge ACLK);
    #1;
    ARVALID_S = 1'b0;
  endtask

  task automatic aw_send(input logic [7:0] id, input logic [31:0] ad,
      input logic [3:0] len, input logic [2:0] sz,
      input logic [1:0] bu, output int hs);
    AWID_S = id; AWADDR_S = ad; AWLEN_S = len;
    AWSIZE_S = sz; AWBURST_S = bu; AWVALID_S = 1'b1;
    hs = -1;
    for (int k = 0; k < 100; k++) begin
      @(negedge ACLK);
      if (AWREADY_S) begin hs = cyc; break; end
    end
    if (hs < 0) chk("aw_timeout", 0, 1);
    @(posedge ACLK);
    #1;
    AWVALID_S = 1'b0;
  endtask

  task automatic w_send(input int nb, input logic [3:0] strb,
      input int last_at, output int first, output int nacc);
    bit got;
    first = -1;
    nacc = 0;
    for (int b = 0; b < nb; b++) begin
      WDATA_S = wdat[b]; WSTRB_S = strb;
      WLAST_S = (b == last_at); WVALID_S = 1'b1;
      got = 0;
      for (int k = 0; k < 100; k++) begin
        @(negedge ACLK);
        if (WREADY_S) begin got = 1; break; end
      end
      if (!got) chk("w_timeout", 0, 1);
      else begin
        if (first < 0) first = cyc;
        wceb[b] = CEB;
        nacc++;
      end
      @(posedge ACLK);
      #1;
    end
    WVALID_S = 1'b0;
    WLAST_S = 1'b0;
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 300; k++) begin
      if (rq.size() == 0 && bq.size() == 0) break;
      @(negedge ACLK);
    end
    if (rq.size() != 0 || bq.size() != 0) chk("drain_timeout", 0, 1);
    repeat (2) @(posedge ACLK);
    #1;
  endtask

  int arc, awc, wf, na, n;

  initial begin
    ARESET = 1'b1; BREADY_S = 1'b1;
    AWID_S = '0; AWADDR_S = '0; AWLEN_S = '0; AWSIZE_S = 3'd2;
    AWBURST_S = 2'b01; AWVALID_S = 1'b1;
    ARID_S = '0; ARADDR_S = '0; ARLEN_S = '0; ARSIZE_S = 3'd2;
    ARBURST_S = 2'b01; ARVALID_S = 1'b1;
    WDATA_S = '0; WSTRB_S = '0; WLAST_S = 1'b0; WVALID_S = 1'b0;

    repeat (3) begin
      @(negedge ACLK);
      chk("rst_ctl", {AWREADY_S, ARREADY_S, WREADY_S, RVALID_S,
                      BVALID_S, CEB, WEB}, 7'b0000011);
    end
    chk("rst_bweb", BWEB, 32'hFFFF_FFFF);
    chk("rst_rdata", {RDATA_S, RID_S, BID_S}, 0);
    @(posedge ACLK);
    #1;
    ARESET = 1'b0;
    @(negedge ACLK);
    chk("rst_arb", {ARREADY_S, AWREADY_S}, 2'b10);
    #1;
    ARVALID_S = 1'b0; AWVALID_S = 1'b0;
    @(posedge ACLK);
    #1;

    wdat[0] = 32'hA0A1A2A3; wdat[1] = 32'hB0B1B2B3;
    wdat[2] = 32'hC0C1C2C3; wdat[3] = 32'hD0D1D2D3;
    bq.push_back(mk_b(8'h01, 2'b00));
    aw_send(8'h01, 32'h100, 4'd3, 3'd2, 2'b01, awc);
    w_send(4, 4'hF, 3, wf, na);
    chk("w_lat", wf - awc, 1);
    @(negedge ACLK);
    chk("b_lat", BVALID_S, 1);
    wait_idle();

    wdat[0] = 32'hCAFEF00D;
    rq.push_back(mk_r(8'h21, 32'hA0A1A2A3, 2'b00, 1'b1));
    bq.push_back(mk_b(8'h22, 2'b00));
    fork
      ar_send(8'h21, 32'h100, 4'd0, 3'd2, 2'b01, arc);
      begin
        aw_send(8'h22, 32'h200, 4'd0, 3'd2, 2'b01, awc);
        w_send(1, 4'hF, 0, wf, na);
      end
    join
    chk("arb1_read_first", arc < awc, 1);
    wait_idle();

    rq.push_back(mk_r(8'h02, 32'hA0A1A2A3, 2'b00, 1'b0));
    rq.push_back(mk_r(8'h02, 32'hB0B1B2B3, 2'b00, 1'b0));
    rq.push_back(mk_r(8'h02, 32'hC0C1C2C3, 2'b00, 1'b0));
    rq.push_back(mk_r(8'h02, 32'hD0D1D2D3, 2'b00, 1'b1));
    ar_send(8'h02, 32'h100, 4'd3, 3'd2, 2'b01, arc);
    @(negedge ACLK);
    chk("r_lat", RVALID_S, 1);
    n = 1;
    while (!(RVALID_S && RREADY_S && RLAST_S) && n < 50) begin
      @(negedge ACLK);
      n++;
    end
    chk("r_thru", n, 4);
    wait_idle();

    rr_tog = 1'b1;
    rq.push_back(mk_r(8'h03, 32'hC0C1C2C3, 2'b00, 1'b0));
    rq.push_back(mk_r(8'h03, 32'hD0D1D2D3, 2'b00, 1'b0));
    rq.push_back(mk_r(8'h03, 32'hA0A1A2A3, 2'b00, 1'b0));
    rq.push_back(mk_r(8'h03, 32'hB0B1B2B3, 2'b00, 1'b1));
    ar_send(8'h03, 32'h108, 4'd3, 3'd2, 2'b10, arc);
    wait_idle();
    rr_tog = 1'b0;
    repeat (2) @(posedge ACLK);
    #1;

    wdat[0] = 32'h0BADBEEF;
    bq.push_back(mk_b(8'h32, 2'b00));
    rq.push_back(mk_r(8'h31, 32'h0BADBEEF, 2'b00, 1'b1));
    fork
      ar_send(8'h31, 32'h204, 4'd0, 3'd2, 2'b01, arc);
      begin
        aw_send(8'h32, 32'h204, 4'd0, 3'd2, 2'b01, awc);
        w_send(1, 4'hF, 0, wf, na);
      end
    join
    chk("arb2_write_first", awc < arc, 1);
    wait_idle();

    wdat[0] = 32'hAABBCCDD;
    bq.push_back(mk_b(8'h41, 2'b00));
    aw_send(8'h41, 32'hFFFC, 4'd0, 3'd2, 2'b01, awc);
    w_send(1, 4'hF, 0, wf, na);
    wait_idle();

    wdat[0] = 32'h11223344; wdat[1] = 32'h55667788;
    bq.push_back(mk_b(8'h42, 2'b10));
    aw_send(8'h42, 32'hFFFC, 4'd1, 3'd2, 2'b01, awc);
    w_send(2, 4'h3, 1, wf, na);
    chk("ceb_good_beat", wceb[0], 0);
    chk("ceb_bad_beat", wceb[1], 1);
    wait_idle();

    rq.push_back(mk_r(8'h43, 32'hAABB3344, 2'b00, 1'b0));
    rq.push_back(mk_r(8'h43, 32'h0, 2'b10, 1'b1));
    ar_send(8'h43, 32'hFFFC, 4'd1, 3'd2, 2'b01, arc);
    wait_idle();

    rq.push_back(mk_r(8'h44, 32'h0, 2'b10, 1'b1));
    ar_send(8'h44, 32'h100, 4'd0, 3'd2, 2'b11, arc);
    wait_idle();

    rq.push_back(mk_r(8'h46, 32'h0, 2'b10, 1'b1));
    ar_send(8'h46, 32'h100, 4'd0, 3'd3, 2'b01, arc);
    wait_idle();

    wdat[0] = 32'h1; wdat[1] = 32'h2; wdat[2] = 32'h3; wdat[3] = 32'h4;
    bq.push_back(mk_b(8'h45, 2'b10));
    aw_send(8'h45, 32'h300, 4'd3, 3'd2, 2'b01, awc);
    w_send(4, 4'hF, 1, wf, na);
    chk("wlast_beats", na, 4);
    wait_idle();

    @(negedge ACLK);
    chk("idle_sram", {CEB, WEB, BWEB, 14'(A), D},
        {1'b1, 1'b1, 32'hFFFF_FFFF, 14'h0, 32'h0});
    chk("rq_empty", rq.size(), 0);
    chk("bq_empty", bq.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1, "timeout");
  end

endmodule
